// File: rtl/sram_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_read_arbiter_pkg
// Shared constants and helpers for the SRAM read arbiter.
//
// Default address/data widths and read latency mirror the global
// SRAM_ADDR_BIT / SRAM_WORD_WIDTH / SRAM_RD_LAT constants of the datapath;
// stand-alone values are used here so the block can be built on its own.
//
// Optional feature macro: SRAM_ARB_FIXED_PRIO_EN (consumed by rr_arbiter).
// -----------------------------------------------------------------------------
package sram_read_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_LAT = 1;

   // Channel-index width; never below one bit so a 2-channel (or 1-channel)
   // build still has a real index signal.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_read_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Single-grant arbiter over N request lines.
//
// Default build: round-robin. The search starts at an internal pointer; after
// a grant to channel k the pointer moves to (k+1) mod N, otherwise it holds.
// With SRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and
// the pointer register does not exist.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointer -> 0)
//   req_i[N]     eligible request vector
//   gnt_o[N]     one-hot grant (zero when no request)
//   gnt_vld_o    a grant is issued this cycle
//   gnt_idx_o    index of the granted channel (valid with gnt_vld_o)
// -----------------------------------------------------------------------------
module rr_arbiter
   import sram_read_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic             gnt_vld_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

`ifdef SRAM_ARB_FIXED_PRIO_EN

   // No state in this mode; clock and reset are kept on the port list so the
   // instantiation is identical in both builds.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      // Walk downwards so the lowest requesting index is the last to win.
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(i);
         end
      end
   end

`else

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;

   always_comb begin
      int cand;
      cand      = 0;
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      ptr_d     = ptr_q;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr_q) + off) % N;
         if (!gnt_vld_o && req_i[cand]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(cand);
            ptr_d     = IDX_W'((cand + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign gnt_o[gi] = gnt_vld_o && (gnt_idx_o == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/sram_read_arbiter.sv
// -----------------------------------------------------------------------------
// sram_read_arbiter
// Shares one single-port synchronous SRAM read interface between NUM_CH
// requesters. Each channel may have at most one read in flight; a grant
// registers the address onto the SRAM and pushes a channel tag into an
// RD_LAT-deep pipeline whose output raises valid_o for that channel exactly
// when the SRAM word appears on sram_data_i (1+RD_LAT cycles after grant).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sram_en_o     registered SRAM read enable
//   sram_addr_o   registered SRAM read address (holds when idle)
//   sram_data_i   SRAM read data
//   req_i         per-channel level request
//   addr_i        per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//   data_o        sram_data_i passed straight through to all channels
//   valid_o       registered one-hot/zero: channel k owns data_o this cycle
//
// Optional feature macro: SRAM_ARB_FIXED_PRIO_EN (fixed priority, ch0 first).
// -----------------------------------------------------------------------------
module sram_read_arbiter
   import sram_read_arbiter_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     sram_en_o,
   output logic [ADDR_W-1:0]        sram_addr_o,
   input  logic [DATA_W-1:0]        sram_data_i,
   input  logic [NUM_CH-1:0]        req_i,
   input  logic [NUM_CH*ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0]        data_o,
   output logic [NUM_CH-1:0]        valid_o
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic              sram_en_q,   sram_en_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [NUM_CH-1:0] valid_q,     valid_d;
   logic [NUM_CH-1:0] inflight_q,  inflight_d;

   logic              tag_v_q  [RD_LAT];
   logic              tag_v_d  [RD_LAT];
   logic [CH_W-1:0]   tag_ch_q [RD_LAT];
   logic [CH_W-1:0]   tag_ch_d [RD_LAT];

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] gnt;
   logic              gnt_vld;
   logic [CH_W-1:0]   gnt_idx;
   logic [ADDR_W-1:0] gnt_addr;
   logic              ret_vld;
   logic [CH_W-1:0]   ret_ch;

   // A channel whose valid_o is high this cycle is masked so its own
   // completion cannot be re-granted in the same cycle.
   assign eligible = req_i & ~inflight_q & ~valid_q;

   rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (CH_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (eligible),
      .gnt_o     (gnt),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   // One-hot AND-OR mux of the granted channel's address.
   always_comb begin
      gnt_addr = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (gnt[k]) begin
            gnt_addr = gnt_addr | addr_i[k*ADDR_W +: ADDR_W];
         end
      end
   end

   // Tag pipeline: stage 0 captures the grant, later stages shift it along.
   genvar gi;
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            assign tag_v_d[gi]  = gnt_vld;
            assign tag_ch_d[gi] = gnt_idx;
         end else begin : g_body
            assign tag_v_d[gi]  = tag_v_q[gi-1];
            assign tag_ch_d[gi] = tag_ch_q[gi-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tag_v_q[gi]  <= 1'b0;
               tag_ch_q[gi] <= '0;
            end else begin
               tag_v_q[gi]  <= tag_v_d[gi];
               tag_ch_q[gi] <= tag_ch_d[gi];
            end
         end
      end
   endgenerate

   assign ret_vld = tag_v_q[RD_LAT-1];
   assign ret_ch  = tag_ch_q[RD_LAT-1];

   always_comb begin
      sram_en_d   = gnt_vld;
      sram_addr_d = gnt_vld ? gnt_addr : sram_addr_q;
      valid_d     = '0;
      inflight_d  = inflight_q;
      // Retire and grant never target the same channel (the retiring channel
      // is still in flight, hence not eligible), so the order is immaterial.
      for (int k = 0; k < NUM_CH; k++) begin
         if (ret_vld && (ret_ch == CH_W'(k))) begin
            valid_d[k]    = 1'b1;
            inflight_d[k] = 1'b0;
         end
         if (gnt[k]) begin
            inflight_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_en_q   <= 1'b0;
         sram_addr_q <= '0;
         valid_q     <= '0;
         inflight_q  <= '0;
      end else begin
         sram_en_q   <= sram_en_d;
         sram_addr_q <= sram_addr_d;
         valid_q     <= valid_d;
         inflight_q  <= inflight_d;
      end
   end

   assign sram_en_o   = sram_en_q;
   assign sram_addr_o = sram_addr_q;
   assign valid_o     = valid_q;
   assign data_o      = sram_data_i;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_read_arbiter
// Directed bench for sram_read_arbiter. dut_a: NUM_CH=4, RD_LAT=1.
// dut_b: NUM_CH=2, RD_LAT=3. Each DUT sees a behavioural SRAM whose word at
// address a is {a, ~a}. Cycle n is the interval after the n-th rising edge
// of a test; inputs change 1ns after the edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_sram_read_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [3:0]      req_a;
   logic [4*AW-1:0] addr_a;
   logic            en_a;
   logic [AW-1:0]   saddr_a;
   logic [DW-1:0]   sdata_a;
   logic [DW-1:0]   data_a;
   logic [3:0]      valid_a;

   logic [1:0]      req_b;
   logic [2*AW-1:0] addr_b;
   logic            en_b;
   logic [AW-1:0]   saddr_b;
   logic [DW-1:0]   sdata_b;
   logic [DW-1:0]   data_b;
   logic [1:0]      valid_b;
   logic [DW-1:0]   pipe_b1, pipe_b2;

   int checks = 0;
   int errors = 0;

   sram_read_arbiter #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .sram_en_o(en_a), .sram_addr_o(saddr_a),
      .sram_data_i(sdata_a), .req_i(req_a), .addr_i(addr_a),
      .data_o(data_a), .valid_o(valid_a));

   sram_read_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .sram_en_o(en_b), .sram_addr_o(saddr_b),
      .sram_data_i(sdata_b), .req_i(req_b), .addr_i(addr_b),
      .data_o(data_b), .valid_o(valid_b));

   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      return {a, ~a};
   endfunction

   // SRAM models: data for the registered address appears RD_LAT cycles later.
   always @(posedge clk) begin
      sdata_a <= mem(saddr_a);
      pipe_b1 <= mem(saddr_b);
      pipe_b2 <= pipe_b1;
      sdata_b <= pipe_b2;
   end

   always @(negedge clk) begin
      if (rst_n && valid_a != 4'd0) $display("xfer dut_a valid=%b data=%h", valid_a, data_a);
      if (rst_n && valid_b != 2'd0) $display("xfer dut_b valid=%b data=%h", valid_b, data_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n = 1'b0;
      req_a = '0;
      req_b = '0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int seq [8];
      logic       t_en [6];
      logic [7:0] t_ad [6];
      logic [3:0] t_va [6];
      logic       b_en [10];
      logic [7:0] b_ad [10];
      logic [1:0] b_va [10];
      logic [7:0] b_da [10];

`ifdef SRAM_ARB_FIXED_PRIO_EN
      seq = '{0, 1, 2, 0, 1, 2, 0, 1};
`else
      seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
      t_en = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      t_ad = '{8'h10, 8'h12, 8'h12, 8'h10, 8'h12, 8'h12};
      t_va = '{4'h0, 4'h1, 4'h4, 4'h0, 4'h1, 4'h4};
      b_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      b_ad = '{8'h30, 8'h31, 8'h31, 8'h31, 8'h31, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41};
      b_va = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
      b_da = '{8'h00, 8'h00, 8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h00, 8'h40, 8'h41};

      // ---- reset state ----
      rst_n  = 1'b0;
      req_a  = '0;
      req_b  = '0;
      addr_a = '0;
      addr_b = '0;
      @(negedge clk);
      chk("rst_en_a",    32'(en_a),    32'd0);
      chk("rst_addr_a",  32'(saddr_a), 32'd0);
      chk("rst_valid_a", 32'(valid_a), 32'd0);
      chk("rst_en_b",    32'(en_b),    32'd0);
      chk("rst_valid_b", 32'(valid_b), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         @(negedge clk);
         chk("idle_en",    32'(en_a),    32'd0);
         chk("idle_valid", 32'(valid_a), 32'd0);
      end

      // ---- single read on ch0, addr 0x05 ----
      next_cycle();
      req_a = 4'b0001;
      addr_a[7:0] = 8'h05;
      next_cycle();
      @(negedge clk);
      chk("single_en_c1",    32'(en_a),    32'd1);
      chk("single_addr_c1",  32'(saddr_a), 32'h05);
      chk("single_valid_c1", 32'(valid_a), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("single_valid_c2", 32'(valid_a), 32'b0001);
      chk("single_data_c2",  32'(data_a),  32'(mem(8'h05)));
      chk("single_en_c2",    32'(en_a),    32'd0);
      req_a = '0;
      next_cycle();
      @(negedge clk);
      chk("single_valid_c3", 32'(valid_a), 32'd0);

      // ---- contention, all four channels; reset first returns pointer to 0 ----
      do_reset();
      next_cycle();
      req_a  = 4'hF;
      addr_a = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         @(negedge clk);
         chk("cont_en",   32'(en_a),    32'd1);
         chk("cont_addr", 32'(saddr_a), 32'h10 + 32'(seq[c-1]));
         if (c >= 2) begin
            chk("cont_valid", 32'(valid_a), 32'd1 << seq[c-2]);
            chk("cont_data",  32'(data_a),  32'(mem(8'(8'h10 + seq[c-2]))));
         end
      end
      req_a = '0;

      // ---- per-channel outstanding limit: ch1 alone ----
      do_reset();
      next_cycle();
      req_a  = 4'b0010;
      addr_a[15:8] = 8'h21;
      for (int c = 1; c <= 9; c++) begin
         next_cycle();
         @(negedge clk);
         chk("limit_en", 32'(en_a), (c % 3 == 1) ? 32'd1 : 32'd0);
         chk("limit_valid", 32'(valid_a), (c % 3 == 2) ? 32'b0010 : 32'd0);
         if (c % 3 == 1) chk("limit_addr", 32'(saddr_a), 32'h21);
      end
      req_a = '0;

      // ---- request dropped after grant still completes ----
      next_cycle();
      req_a = 4'b0100;
      addr_a[23:16] = 8'h32;
      next_cycle();
      req_a = '0;
      @(negedge clk);
      chk("drop_en",   32'(en_a),    32'd1);
      chk("drop_addr", 32'(saddr_a), 32'h32);
      next_cycle();
      @(negedge clk);
      chk("drop_valid", 32'(valid_a), 32'b0100);
      chk("drop_data",  32'(data_a),  32'(mem(8'h32)));

      // ---- reset while a read is in flight ----
      next_cycle();
      req_a = 4'b0001;
      addr_a[7:0] = 8'h05;
      next_cycle();
      rst_n = 1'b0;
      req_a = '0;
      @(negedge clk);
      chk("midrst_en",    32'(en_a),    32'd0);
      chk("midrst_valid", 32'(valid_a), 32'd0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         @(negedge clk);
         chk("midrst_after_valid", 32'(valid_a), 32'd0);
      end

      // ---- ch0 and ch2 continuously requesting ----
      do_reset();
      next_cycle();
      req_a  = 4'b0101;
      addr_a = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         @(negedge clk);
         chk("pair_en",    32'(en_a),    32'(t_en[c-1]));
         chk("pair_addr",  32'(saddr_a), 32'(t_ad[c-1]));
         chk("pair_valid", 32'(valid_a), 32'(t_va[c-1]));
         if (t_va[c-1] == 4'h1) chk("pair_data0", 32'(data_a), 32'(mem(8'h10)));
         if (t_va[c-1] == 4'h4) chk("pair_data2", 32'(data_a), 32'(mem(8'h12)));
      end
      req_a = '0;

      // ---- RD_LAT=3, two channels alternating, new addresses after valid ----
      do_reset();
      next_cycle();
      req_b  = 2'b11;
      addr_b = {8'h31, 8'h30};
      for (int c = 1; c <= 10; c++) begin
         next_cycle();
         if (c == 5) addr_b[7:0]  = 8'h40;
         if (c == 6) addr_b[15:8] = 8'h41;
         @(negedge clk);
         chk("lat3_en",    32'(en_b),    32'(b_en[c-1]));
         chk("lat3_addr",  32'(saddr_b), 32'(b_ad[c-1]));
         chk("lat3_valid", 32'(valid_b), 32'(b_va[c-1]));
         if (b_va[c-1] != 2'd0) chk("lat3_data", 32'(data_b), 32'(mem(b_da[c-1])));
      end
      req_b = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
